// File: rtl/rs_alu_ctrl.sv
// rs_alu_ctrl: ALU reservation-station allocation and oldest-ready issue scheduler
module rs_alu_ctrl #(
  parameter int NENT = 8,
  parameter int ENT_SEL = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NENT-1:0]    i_ent_busy,
  input  logic [NENT-1:0]    i_ent_vld,
  input  logic               i_dp_req0,
  input  logic               i_dp_req1,
  output logic               o_dp_stall,
  output logic [NENT-1:0]    o_wr_en0,
  output logic [NENT-1:0]    o_wr_en1,
  output logic [ENT_SEL:0]   o_free_cnt,
  input  logic               i_alu_rdy,
  output logic [NENT-1:0]    o_rd_en,
  output logic               o_issue_vld,
  output logic [ENT_SEL-1:0] o_issue_sel
);
  logic [NENT-1:0]            free, blk, elig, rd_pick;
  logic [NENT-1:0][NENT-1:0]  age;
  logic [ENT_SEL-1:0]         w0, w1, rd_idx;
  logic [1:0]                 req_n;
  logic                       alloc_ok;
  assign free = ~i_ent_busy;
  always_comb begin
    o_free_cnt = '0;
    w0 = '0;
    w1 = '0;
    for (int i = NENT - 1; i >= 0; i--) w0 = free[i] ? ENT_SEL'(i) : w0;
    for (int i = 0; i < NENT; i++) begin
      w1 = free[i] ? ENT_SEL'(i) : w1;
      o_free_cnt = o_free_cnt + (ENT_SEL+1)'(free[i]);
    end
  end
  assign req_n = {1'b0, i_dp_req0} + {1'b0, i_dp_req0 & i_dp_req1};
  assign o_dp_stall = (ENT_SEL+1)'(req_n) > o_free_cnt;
  assign alloc_ok = !rst && !o_dp_stall;
  assign o_wr_en0 = (alloc_ok && i_dp_req0) ? NENT'(1) << w0 : '0;
  assign o_wr_en1 = (alloc_ok && i_dp_req0 && i_dp_req1) ? NENT'(1) << w1 : '0;
  always_comb begin
    blk = '0;
    for (int i = 0; i < NENT; i++)
      for (int j = 0; j < NENT; j++)
        blk[i] = blk[i] | (i_ent_vld[j] & age[j][i]);
  end
  assign elig = i_ent_vld & ~blk;
  assign rd_pick = elig & (~elig + NENT'(1));
  assign o_rd_en = (!rst && i_alu_rdy) ? rd_pick : '0;
  always_comb begin
    rd_idx = '0;
    for (int i = 0; i < NENT; i++) rd_idx = rd_pick[i] ? ENT_SEL'(i) : rd_idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      age <= '0;
      o_issue_vld <= 1'b0;
      o_issue_sel <= '0;
    end else begin
      for (int i = 0; i < NENT; i++)
        for (int j = 0; j < NENT; j++)
          if (i == j) age[i][j] <= 1'b0;
          else if (o_wr_en0[i]) age[i][j] <= o_wr_en1[j];
          else if (o_wr_en1[i]) age[i][j] <= 1'b0;
          else if (o_wr_en0[j] | o_wr_en1[j]) age[i][j] <= 1'b1;
      o_issue_vld <= |o_rd_en;
      if (|o_rd_en) o_issue_sel <= rd_idx;
    end
  end
endmodule

// File: tb/tb_rs_alu_ctrl.sv
// tb_rs_alu_ctrl: directed and randomized self-checking bench for rs_alu_ctrl
module tb_rs_alu_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] busy, vld;
  logic       req0, req1, alu_rdy;
  logic       stall;
  logic [7:0] wr0, wr1, rd;
  logic [3:0] free_cnt;
  logic       iv;
  logic [2:0] is;
  int total = 0;
  int bad = 0;
  rs_alu_ctrl #(.NENT(8), .ENT_SEL(3)) dut (
    .clk(clk), .rst(rst), .i_ent_busy(busy), .i_ent_vld(vld),
    .i_dp_req0(req0), .i_dp_req1(req1), .o_dp_stall(stall),
    .o_wr_en0(wr0), .o_wr_en1(wr1), .o_free_cnt(free_cnt),
    .i_alu_rdy(alu_rdy), .o_rd_en(rd), .o_issue_vld(iv), .o_issue_sel(is)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    rst = 1'b0; busy = 8'hFF; vld = 8'h00; req0 = 1'b0; req1 = 1'b0; alu_rdy = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1; busy = 8'h00; vld = 8'hFF; req0 = 1'b1; req1 = 1'b1; alu_rdy = 1'b1;
    @(negedge clk);
    total++; if (rd !== 8'h00) begin bad++; $display("FAIL reset_rd got=%h exp=00", rd); end
    total++; if (wr0 !== 8'h00) begin bad++; $display("FAIL reset_wr0 got=%h exp=00", wr0); end
    total++; if (wr1 !== 8'h00) begin bad++; $display("FAIL reset_wr1 got=%h exp=00", wr1); end
    total++; if (free_cnt !== 4'd8) begin bad++; $display("FAIL reset_free got=%0d exp=8", free_cnt); end
    step();
    idle();
    @(negedge clk);
    total++; if (iv !== 1'b0) begin bad++; $display("FAIL reset_iv got=%b exp=0", iv); end
    total++; if (is !== 3'd0) begin bad++; $display("FAIL reset_is got=%0d exp=0", is); end
    step();
  endtask
  task automatic test_dual_dispatch();
    busy = 8'h00; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    total++; if (wr0 !== 8'h01) begin bad++; $display("FAIL dual_wr0 got=%h exp=01", wr0); end
    total++; if (wr1 !== 8'h80) begin bad++; $display("FAIL dual_wr1 got=%h exp=80", wr1); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL dual_stall got=%b exp=0", stall); end
    step();
    idle();
    busy = 8'h81;
    @(negedge clk);
    total++; if (free_cnt !== 4'd6) begin bad++; $display("FAIL dual_free got=%0d exp=6", free_cnt); end
    step();
  endtask
  task automatic test_stall();
    busy = 8'hFE; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL stall_flag got=%b exp=1", stall); end
    total++; if (wr0 !== 8'h00) begin bad++; $display("FAIL stall_wr0 got=%h exp=00", wr0); end
    total++; if (wr1 !== 8'h00) begin bad++; $display("FAIL stall_wr1 got=%h exp=00", wr1); end
    req1 = 1'b0;
    #1;
    total++; if (wr0 !== 8'h01) begin bad++; $display("FAIL single_wr0 got=%h exp=01", wr0); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL single_stall got=%b exp=0", stall); end
    req0 = 1'b0; req1 = 1'b1;
    #1;
    total++; if (stall !== 1'b0 || wr0 !== 8'h00 || wr1 !== 8'h00) begin
      bad++; $display("FAIL req1_only got=%b/%h/%h exp=0/00/00", stall, wr0, wr1);
    end
    step();
    idle();
  endtask
  task automatic test_age_order();
    busy = 8'hDF; req0 = 1'b1;
    @(negedge clk);
    total++; if (wr0 !== 8'h20) begin bad++; $display("FAIL age_alloc5 got=%h exp=20", wr0); end
    step();
    idle();
    step();
    busy = 8'hFE; req0 = 1'b1;
    @(negedge clk);
    total++; if (wr0 !== 8'h01) begin bad++; $display("FAIL age_alloc0 got=%h exp=01", wr0); end
    step();
    idle();
    vld = 8'h21; alu_rdy = 1'b1;
    @(negedge clk);
    total++; if (rd !== 8'h20) begin bad++; $display("FAIL age_rd_old got=%h exp=20", rd); end
    step();
    vld = 8'h01;
    @(negedge clk);
    total++; if (iv !== 1'b1) begin bad++; $display("FAIL age_iv got=%b exp=1", iv); end
    total++; if (is !== 3'd5) begin bad++; $display("FAIL age_is got=%0d exp=5", is); end
    total++; if (rd !== 8'h01) begin bad++; $display("FAIL age_rd_young got=%h exp=01", rd); end
    step();
    idle();
  endtask
  task automatic test_same_cycle();
    busy = 8'hBB; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk);
    total++; if (wr0 !== 8'h04 || wr1 !== 8'h40) begin
      bad++; $display("FAIL pair_alloc got=%h/%h exp=04/40", wr0, wr1);
    end
    step();
    idle();
    vld = 8'h44; alu_rdy = 1'b1;
    @(negedge clk);
    total++; if (rd !== 8'h04) begin bad++; $display("FAIL pair_first got=%h exp=04", rd); end
    step();
    vld = 8'h40;
    @(negedge clk);
    total++; if (rd !== 8'h40) begin bad++; $display("FAIL pair_second got=%h exp=40", rd); end
    total++; if (is !== 3'd2) begin bad++; $display("FAIL pair_is got=%0d exp=2", is); end
    step();
    idle();
  endtask
  task automatic test_backpressure();
    vld = 8'h10; alu_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (rd !== 8'h00) begin bad++; $display("FAIL bp_rd cyc=%0d got=%h exp=00", c, rd); end
      if (c > 0) begin
        total++; if (iv !== 1'b0) begin bad++; $display("FAIL bp_iv cyc=%0d got=%b exp=0", c, iv); end
      end
      step();
    end
    alu_rdy = 1'b1;
    @(negedge clk);
    total++; if (rd !== 8'h10) begin bad++; $display("FAIL bp_release got=%h exp=10", rd); end
    step();
    idle();
    @(negedge clk);
    total++; if (iv !== 1'b1 || is !== 3'd4) begin
      bad++; $display("FAIL bp_issue got=%b/%0d exp=1/4", iv, is);
    end
    step();
  endtask
  // Reference: each entry remembers when it was allocated; the oldest ready entry wins.
  task automatic test_random();
    bit m_busy[8];
    int stamp[8];
    int now = 0;
    int nfree, lo, hi, reqn, oldest;
    bit exp_stall, exp_iv;
    logic [7:0] exp_wr0, exp_wr1, exp_rd;
    logic [2:0] exp_is;
    rst = 1'b1; busy = 8'h00; vld = 8'h00; req0 = 1'b0; req1 = 1'b0; alu_rdy = 1'b0;
    step();
    rst = 1'b0;
    foreach (m_busy[k]) begin m_busy[k] = 1'b0; stamp[k] = 0; end
    exp_iv = 1'b0; exp_is = 3'd0;
    for (int c = 0; c < 400; c++) begin
      req0 = 1'($urandom); req1 = 1'($urandom);
      alu_rdy = $urandom_range(0, 3) != 0;
      nfree = 0; lo = -1; hi = -1;
      for (int k = 0; k < 8; k++) begin
        busy[k] = m_busy[k];
        vld[k] = m_busy[k] && ($urandom_range(0, 2) != 0);
        if (!m_busy[k]) begin nfree++; hi = k; if (lo < 0) lo = k; end
      end
      reqn = req0 ? (req1 ? 2 : 1) : 0;
      exp_stall = reqn > nfree;
      exp_wr0 = (!exp_stall && reqn >= 1) ? 8'(1 << lo) : 8'h00;
      exp_wr1 = (!exp_stall && reqn == 2) ? 8'(1 << hi) : 8'h00;
      oldest = -1;
      for (int k = 0; k < 8; k++)
        if (vld[k] && (oldest < 0 || stamp[k] < stamp[oldest])) oldest = k;
      exp_rd = (alu_rdy && oldest >= 0) ? 8'(1 << oldest) : 8'h00;
      @(negedge clk);
      total++; if (free_cnt !== 4'(nfree)) begin bad++; $display("FAIL rnd_free cyc=%0d got=%0d exp=%0d", c, free_cnt, nfree); end
      total++; if (stall !== exp_stall) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", c, stall, exp_stall); end
      total++; if (wr0 !== exp_wr0 || wr1 !== exp_wr1) begin
        bad++; $display("FAIL rnd_wr cyc=%0d got=%h/%h exp=%h/%h", c, wr0, wr1, exp_wr0, exp_wr1);
      end
      total++; if (rd !== exp_rd) begin bad++; $display("FAIL rnd_rd cyc=%0d got=%h exp=%h vld=%h", c, rd, exp_rd, vld); end
      total++; if (iv !== exp_iv || is !== exp_is) begin
        bad++; $display("FAIL rnd_issue cyc=%0d got=%b/%0d exp=%b/%0d", c, iv, is, exp_iv, exp_is);
      end
      step();
      if (exp_wr0 != 0) begin m_busy[lo] = 1'b1; stamp[lo] = now++; end
      if (exp_wr1 != 0) begin m_busy[hi] = 1'b1; stamp[hi] = now++; end
      exp_iv = exp_rd != 0;
      if (exp_rd != 0) begin m_busy[oldest] = 1'b0; exp_is = 3'(oldest); end
    end
    idle();
  endtask
  initial begin
    idle();
    step();
    test_reset();
    test_dual_dispatch();
    test_stall();
    test_age_order();
    test_same_cycle();
    test_backpressure();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
